gate_drv_monitor: RTL and testbench

- Observes the six gate-drive outputs of mtr_drive (highX/lowX per phase) together with PWM_synch, and decodes them back into per-phase commutation modes and measured high-side on-times.
- Checks the drive for shoot-through and dead-time violations.
- Sits alongside mtr_drive, between it and the power stage / hub_wheel_model. Used as a synthesizable safety monitor and as a self-check for the brushless/mtr_drive pair.

---
 rtl/gate_drv_monitor.sv | 181 ++++++++++++++++++
 tb/tb_gate_drv_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_drv_monitor.sv
// Gate-drive monitor: watches the six gate drives of mtr_drive plus PWM_synch,
// decodes each phase's commutation mode and high-side on-time per PWM window,
// and flags shoot-through and dead-time violations with sticky error bits.
module gate_drv_monitor #(
  parameter int DEAD_MIN = 32,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             highGrn,
  input  logic             lowGrn,
  input  logic             highYlw,
  input  logic             lowYlw,
  input  logic             highBlu,
  input  logic             lowBlu,
  input  logic             PWM_synch,
  input  logic             clr_err,
  output logic [1:0]       selGrn,
  output logic [1:0]       selYlw,
  output logic [1:0]       selBlu,
  output logic [CNT_W-1:0] hiCntGrn,
  output logic [CNT_W-1:0] hiCntYlw,
  output logic [CNT_W-1:0] hiCntBlu,
  output logic             vld,
  output logic             shoot_thru,
  output logic             dead_err
);

  localparam int              OFF_W   = $clog2(DEAD_MIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(DEAD_MIN);

  typedef enum logic { WAIT_SYNC, MEASURE } state_t;
  typedef enum logic [1:0] { G_NONE, G_HIGH, G_LOW } gate_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_close;
  logic   r_vld;
  logic   r_shoot;
  logic   r_dead;

  // Phase index 0 = Grn, 1 = Ylw, 2 = Blu.
  logic [2:0]             w_high;
  logic [2:0]             w_low;
  logic [2:0]             w_shoot;
  logic [2:0]             w_dead_hit;
  logic [2:0][1:0]        w_sel;
  logic [2:0][CNT_W-1:0]  w_hi_cnt;

  assign w_high = {highBlu, highYlw, highGrn};
  assign w_low  = {lowBlu,  lowYlw,  lowGrn};

  // State register: waits for the first synch, then measures forever.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_SYNC;
    else        r_state <= w_state_nxt;
  end

  // Next-state and window-close decode; the pre-lock partial window never closes.
  // NOTE: every output of a combinational block is defaulted first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    case (r_state)
      WAIT_SYNC: if (PWM_synch) w_state_nxt = MEASURE;
      MEASURE:   w_close = PWM_synch;
      default:   w_state_nxt = WAIT_SYNC;
    endcase
  end

  for (genvar p = 0; p < 3; p++) begin : g_ph
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_l_cnt;
    gate_t            r_first;
    gate_t            r_last_on;
    logic [OFF_W-1:0] r_off_cnt;
    logic             r_high_d;
    logic             r_low_d;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [1:0]       w_sel_nxt;
    gate_t            w_gate_now;
    logic             w_rise_h;
    logic             w_rise_l;

    // High wins when both gates are on; shoot-through is flagged separately.
    assign w_gate_now = w_high[p] ? G_HIGH : (w_low[p] ? G_LOW : G_NONE);
    assign w_rise_h   = w_high[p] & ~r_high_d;
    assign w_rise_l   = w_low[p]  & ~r_low_d;
    assign w_shoot[p] = w_high[p] & w_low[p];
    // Handover to the opposite gate too soon; last_on = none covers startup.
    assign w_dead_hit[p] = (r_off_cnt < OFF_MAX) &&
                           ((w_rise_h && (r_last_on == G_LOW)) ||
                            (w_rise_l && (r_last_on == G_HIGH)));
    assign w_sel[p]    = r_sel;
    assign w_hi_cnt[p] = r_hi_cnt;

    // Window counters: reload with the synch-cycle sample, then accumulate and saturate.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_h_cnt <= '0;
        r_l_cnt <= '0;
        r_first <= G_NONE;
      end else if (PWM_synch) begin
        r_h_cnt <= {{(CNT_W-1){1'b0}}, w_high[p]};
        r_l_cnt <= {{(CNT_W-1){1'b0}}, w_low[p]};
        r_first <= w_gate_now;
      end else if (r_state == MEASURE) begin
        if (w_high[p] && (r_h_cnt != CNT_MAX)) r_h_cnt <= r_h_cnt + 1'b1;
        if (w_low[p]  && (r_l_cnt != CNT_MAX)) r_l_cnt <= r_l_cnt + 1'b1;
        if (r_first == G_NONE)                 r_first <= w_gate_now;
      end
    end

    // Classify the closing window from its accumulated counts.
    always_comb begin
      w_sel_nxt = 2'b10;
      if (r_h_cnt == '0)        w_sel_nxt = (r_l_cnt == '0) ? 2'b00 : 2'b11;
      else if (r_l_cnt == '0)   w_sel_nxt = 2'b10;
      else if (r_first == G_LOW) w_sel_nxt = 2'b01;
    end

    // Decoded outputs: load on window close, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sel    <= 2'b00;
        r_hi_cnt <= '0;
      end else if (w_close) begin
        r_sel    <= w_sel_nxt;
        r_hi_cnt <= r_h_cnt;
      end
    end

    // Dead-time tracking: both-off run length, last asserted gate, edge history.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_off_cnt <= '0;
        r_last_on <= G_NONE;
        r_high_d  <= 1'b0;
        r_low_d   <= 1'b0;
      end else begin
        r_high_d <= w_high[p];
        r_low_d  <= w_low[p];
        if (w_gate_now == G_NONE) begin
          if (r_off_cnt != OFF_MAX) r_off_cnt <= r_off_cnt + 1'b1;
        end else begin
          r_off_cnt <= '0;
          r_last_on <= w_gate_now;
        end
      end
    end
  end

  // Valid pulse and sticky error flags; a new violation beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_shoot <= 1'b0;
      r_dead  <= 1'b0;
    end else begin
      r_vld   <= w_close;
      r_shoot <= (|w_shoot)    | (r_shoot & ~clr_err);
      r_dead  <= (|w_dead_hit) | (r_dead  & ~clr_err);
    end
  end

  assign selGrn     = w_sel[0];
  assign selYlw     = w_sel[1];
  assign selBlu     = w_sel[2];
  assign hiCntGrn   = w_hi_cnt[0];
  assign hiCntYlw   = w_hi_cnt[1];
  assign hiCntBlu   = w_hi_cnt[2];
  assign vld        = r_vld;
  assign shoot_thru = r_shoot;
  assign dead_err   = r_dead;

endmodule

// File: tb/tb_gate_drv_monitor.sv
// Directed bench for gate_drv_monitor: mode decode, on-time counts, sticky
// shoot-through / dead-time flags, reset mid-window and missing-synch saturation.
module tb_gate_drv_monitor;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;
  logic             PWM_synch, clr_err;
  logic [1:0]       selGrn, selYlw, selBlu;
  logic [CNT_W-1:0] hiCntGrn, hiCntYlw, hiCntBlu;
  logic             vld, shoot_thru, dead_err;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  int vld_base;
  // Gate pattern per phase (0 Grn, 1 Ylw, 2 Blu): on for window clocks [start..end].
  int hs[3], he[3], ls[3], le[3];

  gate_drv_monitor #(.DEAD_MIN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .highGrn(highGrn), .lowGrn(lowGrn), .highYlw(highYlw), .lowYlw(lowYlw),
    .highBlu(highBlu), .lowBlu(lowBlu),
    .PWM_synch(PWM_synch), .clr_err(clr_err),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .hiCntGrn(hiCntGrn), .hiCntYlw(hiCntYlw), .hiCntBlu(hiCntBlu),
    .vld(vld), .shoot_thru(shoot_thru), .dead_err(dead_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gates_off();
    {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} = '0;
  endtask

  task automatic idle(input int n);
    gates_off();
    repeat (n) step();
  endtask

  task automatic set_pat(input int p, input int h0, input int h1, input int l0, input int l1);
    hs[p] = h0; he[p] = h1; ls[p] = l0; le[p] = l1;
  endtask

  function automatic logic on(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  // One PWM window: synch at clock 0, gates from the pattern table.
  task automatic window(input int len);
    for (int k = 0; k < len; k++) begin
      PWM_synch = (k == 0);
      highGrn = on(k, hs[0], he[0]); lowGrn = on(k, ls[0], le[0]);
      highYlw = on(k, hs[1], he[1]); lowYlw = on(k, ls[1], le[1]);
      highBlu = on(k, hs[2], he[2]); lowBlu = on(k, ls[2], le[2]);
      step();
      if (vld) vld_cnt++;
    end
    PWM_synch = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] sg, input int hg,
                           input logic [1:0] sy, input int hy,
                           input logic [1:0] sb, input int hb);
    check({tag, " selGrn"},   32'(selGrn),   32'(sg));
    check({tag, " hiCntGrn"}, 32'(hiCntGrn), 32'(hg));
    check({tag, " selYlw"},   32'(selYlw),   32'(sy));
    check({tag, " hiCntYlw"}, 32'(hiCntYlw), 32'(hy));
    check({tag, " selBlu"},   32'(selBlu),   32'(sb));
    check({tag, " hiCntBlu"}, 32'(hiCntBlu), 32'(hb));
  endtask

  task automatic check_flags(input string tag, input logic st, input logic de);
    check({tag, " shoot_thru"}, 32'(shoot_thru), 32'(st));
    check({tag, " dead_err"},   32'(dead_err),   32'(de));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; PWM_synch = 1'b0; clr_err = 1'b0;
    gates_off();
    for (int p = 0; p < 3; p++) set_pat(p, -1, -2, -1, -2);
    repeat (3) step();

    // Reset state
    check_all("reset", 2'b00, 0, 2'b00, 0, 2'b00, 0);
    check("reset vld", 32'(vld), 0);
    check_flags("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Frwd decode on Grn, Ylw/Blu off: first synch locks, second closes window 1
    set_pat(0, 32, 1055, 1088, 2015);
    window(2048);
    check("frwd no vld on lock", 32'(vld_cnt), 0);
    window(2048);
    check("frwd vld once", 32'(vld_cnt), 1);
    check_all("frwd", 2'b10, 1024, 2'b00, 0, 2'b00, 0);
    check_flags("frwd", 1'b0, 1'b0);

    // Rev on Ylw, brake (low only) on Blu
    set_pat(1, 1088, 2015, 32, 1055);
    set_pat(2, -1, -2, 0, 1023);
    window(2048);
    check("pre-rev vld", 32'(vld_cnt), 2);
    check_all("pre-rev", 2'b10, 1024, 2'b00, 0, 2'b00, 0);
    window(2048);
    check("rev vld", 32'(vld_cnt), 3);
    check_all("rev", 2'b10, 1024, 2'b01, 928, 2'b11, 0);
    check_flags("rev", 1'b0, 1'b0);

    // Shoot-through on Blu, sticky until clr_err, set wins over clr_err
    idle(40);
    highBlu = 1'b1; lowBlu = 1'b1;
    check("shoot before edge", 32'(shoot_thru), 0);
    step();
    check("shoot set", 32'(shoot_thru), 1);
    idle(5);
    check("shoot held", 32'(shoot_thru), 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("shoot cleared", 32'(shoot_thru), 0);
    idle(40);
    highBlu = 1'b1; lowBlu = 1'b1; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("shoot set beats clr", 32'(shoot_thru), 1);
    idle(1);
    check("shoot held after clr", 32'(shoot_thru), 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check_flags("shoot final", 1'b0, 1'b0);

    // Dead time on Grn: 10-clock gap -> error, 32 -> ok, 31 -> error
    highGrn = 1'b1; step();
    repeat (4) step();
    idle(10);
    check("dead before low", 32'(dead_err), 0);
    lowGrn = 1'b1; step();
    check("dead gap10", 32'(dead_err), 1);
    gates_off(); clr_err = 1'b1; step(); clr_err = 1'b0;
    check("dead cleared", 32'(dead_err), 0);
    repeat (31) step();
    highGrn = 1'b1; step();
    check("dead gap32 ok", 32'(dead_err), 0);
    repeat (3) step();
    idle(31);
    lowGrn = 1'b1; step();
    check("dead gap31", 32'(dead_err), 1);
    gates_off();

    // Reset mid-window clears everything asynchronously
    set_pat(1, -1, -2, -1, -2);
    set_pat(2, -1, -2, -1, -2);
    window(500);
    #2 rst_n = 1'b0;
    #1;
    check_all("async rst", 2'b00, 0, 2'b00, 0, 2'b00, 0);
    check("async rst vld", 32'(vld), 0);
    check_flags("async rst", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // Startup: partial window (Grn high) discarded, first synch gives no vld
    highGrn = 1'b1;
    repeat (100) step();
    set_pat(1, 1088, 2015, 32, 1055);
    set_pat(2, -1, -2, 0, 1023);
    vld_base = vld_cnt;
    window(2048);
    check("restart no vld", 32'(vld_cnt - vld_base), 0);
    window(2048);
    check("restart vld", 32'(vld_cnt - vld_base), 1);
    check_all("restart", 2'b10, 1024, 2'b01, 928, 2'b11, 0);
    check_flags("restart", 1'b0, 1'b0);

    // Missing synch: highGrn held for 5000 clocks, counters saturate internally
    gates_off(); highGrn = 1'b1; PWM_synch = 1'b1;
    step();
    PWM_synch = 1'b0;
    check("miss close vld", 32'(vld), 1);
    n = 0;
    repeat (5000) begin
      step();
      if (vld) n++;
    end
    check("miss no vld", 32'(n), 0);
    check("miss hold hiCntGrn", 32'(hiCntGrn), 1024);
    PWM_synch = 1'b1;
    step();
    PWM_synch = 1'b0;
    check("miss vld", 32'(vld), 1);
    check_all("miss", 2'b10, 4095, 2'b00, 0, 2'b00, 0);
    check_flags("miss", 1'b0, 1'b0);
    gates_off();
    step();
    check("vld one-shot", 32'(vld), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
